// File: rtl/ex_multicycle_pkg.sv
// Shared decode constants and FSM state encoding for the ex_multicycle execute stage.
package ex_multicycle_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ex_multicycle_div.sv
// ex_div: iterative restoring divider, one quotient bit per cycle plus one
// sign-fix cycle during which done is high and the results are valid.
module ex_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN + 1);

    logic            busy;
    logic            fix;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dsor;
    logic [XLEN-1:0] dvnd;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    // Operand magnitudes and the trial subtraction of one restoring step.
    always_comb begin
        a_mag   = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
        b_mag   = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, dsor};
    end

    // Iteration state: load on start, one bit per cycle, then the sign-fix cycle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy     <= 1'b0;
            fix      <= 1'b0;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dsor     <= '0;
            dvnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            fix      <= 1'b0;
            cnt      <= CW'(XLEN);
            quo      <= a_mag;
            rem      <= '0;
            dsor     <= b_mag;
            dvnd     <= dividend;
            neg_q    <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r    <= is_signed & dividend[XLEN-1];
            div_zero <= (divisor == '0);
        end else if (busy && !fix) begin
            quo <= {quo[XLEN-2:0], ~trial[XLEN]};
            rem <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            cnt <= cnt - CW'(1);
            fix <= (cnt == CW'(1));
        end else if (fix) begin
            busy <= 1'b0;
            fix  <= 1'b0;
        end else begin
            busy <= busy;
        end
    end

    // Sign correction; a zero divisor bypasses it to give all-ones / dividend.
    always_comb begin
        done = fix;
        if (div_zero) begin
            quotient  = '1;
            remainder = dvnd;
        end else begin
            quotient  = neg_q ? -quo : quo;
            remainder = neg_r ? -rem : rem;
        end
    end

endmodule

// File: rtl/ex_multicycle.sv
// ex_multicycle: execute stage with single-cycle ALU, iterative multiplier and
// optional iterative divider (enabled by defining EX_MULTICYCLE_DIV_EN).
module ex_multicycle
    import ex_multicycle_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    input  logic [31:0]     inst_i,
    input  logic [31:0]     inst_addr_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            reg_wen_i,
    output logic            valid_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            reg_wen_o,
    output logic            hold_o
);
    localparam int SHW    = $clog2(XLEN);
    localparam int MSTEPS = XLEN / MUL_BITS_PER_CYCLE;
    localparam int MCW    = $clog2(MSTEPS + 1);

    state_e            state;
    state_e            next_state;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic              is_mul;
    logic              is_div;
    logic              accept;
    logic              kill;
    logic              alu_ok;
    logic [XLEN-1:0]   alu_res;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   sra_res;
    logic [XLEN-1:0]   srl_res;
    logic              a_neg;
    logic              b_neg;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] step_sum;
    logic [2*XLEN-1:0] prod;
    logic [MCW-1:0]    mcnt;
    logic              mfix;
    logic              mneg;
    logic [XLEN-1:0]   mul_res;
    logic [2:0]        pend_f3;
    logic [4:0]        pend_rd;
    logic              pend_wen;
    logic              div_done;
    logic [XLEN-1:0]   div_res;
    logic              out_valid;
    logic [4:0]        out_rd;
    logic [XLEN-1:0]   out_data;
    logic              out_wen;
    logic              unused_bits;

    assign opcode      = inst_i[6:0];
    assign func3       = inst_i[14:12];
    assign func7       = inst_i[31:25];
    assign shamt       = op2_i[SHW-1:0];
    assign ready_o     = (state == ST_IDLE);
    assign accept      = valid_i & ready_o & ~flush_i;
    assign is_mul      = (opcode == OPC_OP) && (func7 == F7_MULDIV) && !func3[2];
    assign unused_bits = ^{inst_addr_i, inst_i[24:15], inst_i[11:7]};

`ifdef EX_MULTICYCLE_DIV_EN
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rmd;

    assign is_div  = (opcode == OPC_OP) && (func7 == F7_MULDIV) && func3[2];
    assign div_res = pend_f3[1] ? rmd : quot;

    ex_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush_i),
        .start     (accept & is_div),
        .is_signed (~func3[0]),
        .dividend  (op1_i),
        .divisor   (op2_i),
        .done      (div_done),
        .quotient  (quot),
        .remainder (rmd)
    );
`else
    assign is_div   = 1'b0;
    assign div_done = 1'b0;
    assign div_res  = '0;
`endif

    // Single-cycle ALU for OP-IMM and base/alternate OP encodings.
    always_comb begin
        sra_res = $signed(op1_i) >>> shamt;
        srl_res = op1_i >> shamt;
        alu_ok  = 1'b0;
        alu_res = '0;
        if ((opcode == OPC_OP_IMM) || ((opcode == OPC_OP) && (func7 == F7_BASE))) begin
            alu_ok = 1'b1;
            case (func3)
                F3_ADD:  alu_res = op1_i + op2_i;
                F3_SLL:  alu_res = op1_i << shamt;
                F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
                F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
                F3_XOR:  alu_res = op1_i ^ op2_i;
                F3_SR:   alu_res = inst_i[30] ? sra_res : srl_res;
                F3_OR:   alu_res = op1_i | op2_i;
                F3_AND:  alu_res = op1_i & op2_i;
                default: alu_ok  = 1'b0;
            endcase
        end else if ((opcode == OPC_OP) && (func7 == F7_ALT)) begin
            case (func3)
                F3_ADD: begin
                    alu_ok  = 1'b1;
                    alu_res = op1_i - op2_i;
                end
                F3_SR: begin
                    alu_ok  = 1'b1;
                    alu_res = sra_res;
                end
                default: alu_ok = 1'b0;
            endcase
        end else begin
            alu_ok = 1'b0;
        end
    end

    // Multiplier: one shift-add step on magnitudes, then the signed product select.
    always_comb begin
        a_neg    = op1_i[XLEN-1] & ((func3 == F3_MULH) || (func3 == F3_MULHSU));
        b_neg    = op2_i[XLEN-1] & (func3 == F3_MULH);
        step_sum = acc;
        for (int b = 0; b < MUL_BITS_PER_CYCLE; b++) begin
            if (mplier[b]) begin
                step_sum = step_sum + (mcand << b);
            end else begin
                step_sum = step_sum;
            end
        end
        prod    = mneg ? -acc : acc;
        mul_res = (pend_f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Multiplier datapath and the pending destination of a multi-cycle op.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            mcnt     <= '0;
            mfix     <= 1'b0;
            mneg     <= 1'b0;
            pend_f3  <= 3'd0;
            pend_rd  <= 5'd0;
            pend_wen <= 1'b0;
        end else if (accept && (is_mul || is_div)) begin
            mcand    <= {{XLEN{1'b0}}, (a_neg ? -op1_i : op1_i)};
            mplier   <= b_neg ? -op2_i : op2_i;
            acc      <= '0;
            mcnt     <= MCW'(MSTEPS);
            mfix     <= 1'b0;
            mneg     <= a_neg ^ b_neg;
            pend_f3  <= func3;
            pend_rd  <= rd_addr_i;
            pend_wen <= reg_wen_i & (rd_addr_i != 5'd0);
        end else if ((state == ST_MUL) && !mfix) begin
            acc    <= step_sum;
            mcand  <= mcand << MUL_BITS_PER_CYCLE;
            mplier <= mplier >> MUL_BITS_PER_CYCLE;
            mcnt   <= mcnt - MCW'(1);
            mfix   <= (mcnt == MCW'(1));
        end else begin
            mfix <= mfix;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: flush aborts any in-flight multi-cycle op.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    next_state = ST_MUL;
                end else if (accept && is_div) begin
                    next_state = ST_DIV;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    next_state = ST_IDLE;
                end else if (mfix) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_MUL;
                end
            end
            ST_DIV: begin
                if (flush_i) begin
                    next_state = ST_IDLE;
                end else if (div_done) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_DIV;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Result registers: loaded for exactly one cycle, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rd    <= 5'd0;
            out_data  <= '0;
            out_wen   <= 1'b0;
        end else if (accept && !is_mul && !is_div) begin
            out_valid <= 1'b1;
            out_rd    <= rd_addr_i;
            out_data  <= alu_ok ? alu_res : '0;
            out_wen   <= alu_ok & reg_wen_i & (rd_addr_i != 5'd0);
        end else if ((state == ST_MUL) && mfix && !flush_i) begin
            out_valid <= 1'b1;
            out_rd    <= pend_rd;
            out_data  <= mul_res;
            out_wen   <= pend_wen;
        end else if ((state == ST_DIV) && div_done && !flush_i) begin
            out_valid <= 1'b1;
            out_rd    <= pend_rd;
            out_data  <= div_res;
            out_wen   <= pend_wen;
        end else begin
            out_valid <= 1'b0;
            out_rd    <= 5'd0;
            out_data  <= '0;
            out_wen   <= 1'b0;
        end
    end

    // A flush landing in DONE suppresses the completing result.
    assign kill      = flush_i & (state == ST_DONE);
    assign valid_o   = out_valid & ~kill;
    assign rd_addr_o = kill ? 5'd0 : out_rd;
    assign rd_data_o = kill ? '0 : out_data;
    assign reg_wen_o = out_wen & ~kill;
    assign hold_o    = (state != ST_IDLE);

endmodule

// File: doc/ex_multicycle.md
EX_MULTICYCLE -- requirements
Module: ex_multicycle

Interface
REQ-001 Parameter: XLEN, 32, datapath width of operands and result (32 or 64).
REQ-002 Parameter: MUL_BITS_PER_CYCLE, 1, multiplier partial-product bits retired per cycle (1, 2 or 4; divides XLEN).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: valid_i  input  1  instruction present from id_ex.
REQ-006 Port: ready_o  output  1  block can accept an instruction this cycle.
REQ-007 Port: flush_i  input  1  abort the in-flight instruction.
REQ-008 Port: inst_i  input  32  instruction word.
REQ-009 Port: inst_addr_i  input  32  instruction address, carried for debug only.
REQ-010 Port: op1_i / op2_i  input  XLEN  rs1 value / rs2 value or sign-extended immediate.
REQ-011 Port: rd_addr_i  input  5  destination register.
REQ-012 Port: reg_wen_i  input  1  decoder write enable.
REQ-013 Port: valid_o  output  1  one-cycle pulse: result outputs valid.
REQ-014 Port: rd_addr_o  output  5  destination register.
REQ-015 Port: rd_data_o  output  XLEN  result.
REQ-016 Port: reg_wen_o  output  1  register-file write strobe.
REQ-017 Port: hold_o  output  1  pipeline stall request, high while a multi-cycle op is in flight.

Function
REQ-018 An instruction SHALL be accepted on a cycle where valid_i & ready_o & !flush_i; ready_o = (state==IDLE).
REQ-019 Single-cycle ops (opcode 0010011 ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI; opcode 0110011 with func7 0000000 or 0100000) SHALL produce registered outputs with valid_o=1 on the cycle after acceptance.
REQ-020 SUB SHALL compute op1_i - op2_i modulo 2^XLEN; shift amount SHALL be op2_i[log2(XLEN)-1:0].
REQ-021 M ops (opcode 0110011, func7 0000001) MUL/MULH/MULHSU/MULHU SHALL run iteratively in state MUL for XLEN/MUL_BITS_PER_CYCLE cycles, plus one cycle for sign correction, then state DONE.
REQ-022 DIV/DIVU/REM/REMU SHALL run restoring division in state DIV for XLEN cycles, plus one sign-fix cycle, then state DONE.
REQ-023 FSM states: IDLE -> MUL|DIV on accept of an M op; MUL|DIV -> DONE on final iteration; DONE -> IDLE unconditionally (valid_o=1 in DONE).
REQ-024 hold_o SHALL be 1 in MUL, DIV and DONE, and 0 in IDLE.
REQ-025 Divide by zero SHALL give quotient all-ones and remainder = op1; signed overflow (-2^(XLEN-1) / -1) SHALL give quotient = op1 and remainder 0; both SHALL complete in the normal latency.
REQ-026 reg_wen_o SHALL equal reg_wen_i of the accepted instruction AND (rd_addr != 0), asserted only with valid_o.
REQ-027 Unsupported opcode/func combinations SHALL complete single-cycle with valid_o=1, reg_wen_o=0, rd_data_o=0.
REQ-028 flush_i in MUL/DIV/DONE SHALL return the FSM to IDLE next cycle with no valid_o pulse; flush_i has priority over simultaneous valid_i.
REQ-029 Outside a valid_o cycle, rd_data_o, rd_addr_o and reg_wen_o SHALL be 0.

Reset
REQ-030 On rst, state=IDLE and valid_o, reg_wen_o, hold_o, rd_addr_o, rd_data_o SHALL all be 0; rst mid-operation discards the operation.
REQ-031 ready_o SHALL be 1 in the cycle after rst deasserts.

Configuration
REQ-032 Macro EX_MULTICYCLE_DIV_EN: when defined, DIV/DIVU/REM/REMU are implemented per REQ-022/025; when undefined, the DIV state and datapath are absent and those ops behave per REQ-027.

Structure
REQ-033 Opcode, func3 and func7 constants and the FSM state enumeration SHALL live in the shared defines include.
REQ-034 The iterative divider SHALL be a sub-module ex_div (start/done handshake, signed/unsigned flag), instantiated only under EX_MULTICYCLE_DIV_EN.

Verification
REQ-035 ADD op1=5, op2=3, rd=7 -> next cycle valid_o=1, rd_data_o=8, reg_wen_o=1, hold_o=0.
REQ-036 SUB op1=3, op2=5 -> rd_data_o=0xFFFFFFFE.
REQ-037 MUL op1=0xFFFFFFFF, op2=2, MUL_BITS_PER_CYCLE=1 -> hold_o high 34 cycles, then valid_o with 0xFFFFFFFE; MULH -> 0xFFFFFFFF.
REQ-038 DIV op1=7, op2=0 -> 0xFFFFFFFF; REM -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; with macro undefined -> reg_wen_o=0.
REQ-039 flush_i asserted at cycle 10 of DIV -> IDLE next cycle, no valid_o, following ADDI accepted normally.
REQ-040 rst asserted mid-MUL -> all outputs 0 next cycle, ready_o=1 after release; ADDI with rd=0 -> reg_wen_o=0.
